ai_move_engine: RTL and testbench
=================================

// Module: ai_move_engine
// PURPOSE
//  Sequential tic-tac-toe AI move generator for an NxN board. Replaces the fixed 3x3 lookup-table AI with a
//  rule engine: win > block > center > corner > first empty. Scans one line per cycle and returns a
//  one-hot move via a start/done handshake. Sits between the board-state registers and the game controller.
// PARAMETERS
//  N      3          board side length (N >= 3). Cells = N*N, lines L = 2N+2.
//  CELLS  N*N        derived, not overridden.
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      request a move; sampled only in IDLE
//  ai_is_x     in   1      1: AI owns x_state, 0: AI owns o_state; latched with start
//  x_state     in   CELLS  X occupancy; cell (r,c) = bit CELLS-1-(r*N+c) (MSB = top-left)
//  o_state     in   CELLS  O occupancy, same mapping
//  busy        out  1      high from the edge accepting start until DONE is left
//  done        out  1      one-cycle pulse; move/err valid while done=1 and held until next start
//  move        out  CELLS  one-hot chosen cell; all-zero if error or board full
//  err         out  1      1: latched boards overlap (x & o != 0)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, line index 0, busy=0, done=0, move=0, err=0, latches cleared.
//  - States: IDLE, CHECK, SCAN_WIN, SCAN_BLK, PICK, DONE. Edge numbering: edge 0 = edge sampling start=1.
//  - IDLE: start=1 -> latch x, o, ai_is_x; own/opp boards derived from ai_is_x; -> CHECK; busy=1.
//  - CHECK: overlap -> err=1, move=0 -> DONE. Else, full board (x|o all ones) -> move=0, err=0 -> DONE.
//    Else -> SCAN_WIN, idx=0. DONE entered at edge 2 in both terminal cases.
//  - Line order idx 0..L-1: rows top->bottom, columns left->right, main diag (TL->BR), anti-diag (TR->BL).
//  - SCAN_WIN: line idx holds N-1 own cells and exactly 1 empty -> move = that cell, -> DONE.
//    Else idx++; after idx L-1 -> SCAN_BLK, idx=0. Hit on line k: DONE at edge 2+k.
//  - SCAN_BLK: same test against opponent cells. Hit on line k: DONE at edge L+2+k.
//    Lowest idx wins when several lines qualify (both phases).
//  - PICK (entered at edge 2L+1): N odd and centre empty -> centre; else first empty of TL, TR, BL, BR;
//    else lowest row-major empty cell. DONE at edge 2L+2.
//  - DONE: done=1 for exactly one cycle, busy=1 in that cycle; -> IDLE, busy=0. move/err hold until next
//    accepted start, which clears them at edge 0.
//  - start while busy: ignored, no re-latch. Input changes after edge 0: no effect.
//  - rst_n low mid-operation: immediate IDLE, all outputs 0, no done pulse.
//  - move is always one-hot or zero; never selects an occupied cell.
//  - No turn-count legality check; no game-over detection (controller's job).
//  - Line index width clog2(2N+2); every cell/line mask is derived from N at elaboration, no fixed tables.
// TESTING (N=3 unless stated; L=8)
//  1 empty board, ai_is_x=1 -> move=9'b000010000 (centre), err=0, done at edge 18, busy low after.
//  2 X=9'b110000000, O=9'b000011000, ai_is_x=1 -> win row0: move=9'b001000000, done at edge 2.
//  3 X=9'b100000000, O=9'b000011000, ai_is_x=1 -> block row1: move=9'b000100000, done at edge 11.
//  4 X=O=9'b000010000 -> err=1, move=0, done at edge 2; X=9'b101011010, O=9'b010100101 -> err=0, move=0, edge 2.
//  5 start re-pulsed at edges 3..5 of case 1 ignored (single done, same move); rst_n low at edge 5 of case 1
//    -> busy/done/move/err 0 immediately, no done pulse; new start afterwards completes normally.
//  6 N=4, empty board -> move=16'h8000 (TL corner, even N skips centre), done at edge 22.

Source files
------------

// File: rtl/ai_move_engine.sv
// Sequential tic-tac-toe move generator for an NxN board. Rule priority:
// win > block > centre > corner > first empty. One board line is scanned per cycle.
module ai_move_engine #(
  parameter int N = 3,
  localparam int CELLS = N * N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ai_is_x,
  input  logic [CELLS-1:0] x_state,
  input  logic [CELLS-1:0] o_state,
  output logic             busy,
  output logic             done,
  output logic [CELLS-1:0] move,
  output logic             err
);

  localparam int L  = 2 * N + 2;
  localparam int IW = $clog2(L);
  localparam logic [IW-1:0] LastIdx = IW'(L - 1);
  localparam int Centre = CELLS - 1 - ((N / 2) * N + N / 2);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCheck   = 3'd1;
  localparam logic [2:0] StScanWin = 3'd2;
  localparam logic [2:0] StScanBlk = 3'd3;
  localparam logic [2:0] StPick    = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  // Line k: rows 0..N-1, columns N..2N-1, main diagonal 2N, anti-diagonal 2N+1.
  function automatic logic [CELLS-1:0] mask_of(input int k);
    logic [CELLS-1:0] m;
    m = '0;
    for (int j = 0; j < N; j++) begin
      if (k < N)           m[CELLS-1-(k*N+j)]         = 1'b1;
      else if (k < 2 * N)  m[CELLS-1-(j*N+(k-N))]     = 1'b1;
      else if (k == 2 * N) m[CELLS-1-(j*N+j)]         = 1'b1;
      else                 m[CELLS-1-(j*N+(N-1-j))]   = 1'b1;
    end
    return m;
  endfunction

  function automatic int popcount(input logic [CELLS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < CELLS; i++) n += int'(v[i]);
    return n;
  endfunction

  // Highest set bit is the lowest row-major cell.
  function automatic logic [CELLS-1:0] first_empty(input logic [CELLS-1:0] v);
    logic [CELLS-1:0] r;
    r = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  logic [CELLS-1:0] line_mask [L];
  for (genvar k = 0; k < L; k++) begin : g_mask
    assign line_mask[k] = mask_of(k);
  end

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CELLS-1:0] x_q, x_d, o_q, o_d, move_q, move_d;
  logic             ai_x_q, ai_x_d, err_q, err_d;

  logic [CELLS-1:0] own, opp, empty, cur_line, pick;
  logic             own_hit, opp_hit;

  always_comb begin
    own      = ai_x_q ? x_q : o_q;
    opp      = ai_x_q ? o_q : x_q;
    empty    = ~(x_q | o_q);
    cur_line = line_mask[idx_q];
    own_hit  = (popcount(own & cur_line) == N - 1) && (popcount(empty & cur_line) == 1);
    opp_hit  = (popcount(opp & cur_line) == N - 1) && (popcount(empty & cur_line) == 1);

    pick = '0;
    if ((N % 2 == 1) && empty[Centre]) pick[Centre]  = 1'b1;
    else if (empty[CELLS-1])           pick[CELLS-1] = 1'b1;
    else if (empty[CELLS-N])           pick[CELLS-N] = 1'b1;
    else if (empty[N-1])               pick[N-1]     = 1'b1;
    else if (empty[0])                 pick[0]       = 1'b1;
    else                               pick          = first_empty(empty);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    o_d     = o_q;
    ai_x_d  = ai_x_q;
    move_d  = move_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = x_state;
          o_d     = o_state;
          ai_x_d  = ai_is_x;
          move_d  = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        // Terminal boards pass through PICK so DONE lands one edge later.
        if ((x_q & o_q) != '0) begin
          err_d   = 1'b1;
          state_d = StPick;
        end else if (&(x_q | o_q)) begin
          state_d = StPick;
        end else begin
          idx_d   = '0;
          state_d = StScanWin;
        end
      end
      StScanWin: begin
        if (own_hit) begin
          move_d  = empty & cur_line;
          state_d = StDone;
        end else if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StScanBlk;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StScanBlk: begin
        if (opp_hit) begin
          move_d  = empty & cur_line;
          state_d = StDone;
        end else if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StPick;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StPick: begin
        move_d  = err_q ? '0 : pick;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      x_q     <= '0;
      o_q     <= '0;
      ai_x_q  <= 1'b0;
      move_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      o_q     <= o_d;
      ai_x_q  <= ai_x_d;
      move_q  <= move_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign move = move_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ai_move_engine.sv
// Bench for ai_move_engine: directed table, random boards against a rule-level
// model, start re-pulse, mid-run reset, and an N=4 instance.
module tb_ai_move_engine;

  logic        clk = 1'b0;
  logic        rst_n, start, ai_is_x;
  logic [8:0]  x_state, o_state, move;
  logic        busy, done, err;
  logic        start4;
  logic [15:0] x4, o4, move4;
  logic        busy4, done4, err4;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ai_move_engine #(.N(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ai_is_x(ai_is_x),
    .x_state(x_state), .o_state(o_state),
    .busy(busy), .done(done), .move(move), .err(err)
  );

  ai_move_engine #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .ai_is_x(ai_is_x),
    .x_state(x4), .o_state(o4),
    .busy(busy4), .done(done4), .move(move4), .err(err4)
  );

  typedef struct {
    logic [8:0] x;
    logic [8:0] o;
    logic       aix;
    logic [8:0] mv;
    logic       er;
    int         lat;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Rule-level model on a 3x3 board using row-major positions p = r*3+c (bit 8-p).
  function automatic void model(input logic [8:0] x, input logic [8:0] o, input logic aix,
                                output logic [8:0] mv, output logic er, output int lat);
    int cells[8][3];
    logic [8:0] own, opp, mine;
    int cnt, emp, epos;
    mv = '0;
    er = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        cells[k][j]   = k * 3 + j;
        cells[3+k][j] = j * 3 + k;
      end
      cells[6][k] = k * 3 + k;
      cells[7][k] = k * 3 + (2 - k);
    end
    if ((x & o) != 0) begin er = 1'b1; lat = 2; return; end
    if ((x | o) == 9'h1FF) begin lat = 2; return; end
    own = aix ? x : o;
    opp = aix ? o : x;
    for (int ph = 0; ph < 2; ph++) begin
      mine = (ph == 0) ? own : opp;
      for (int k = 0; k < 8; k++) begin
        cnt = 0; emp = 0; epos = 0;
        for (int j = 0; j < 3; j++) begin
          if (mine[8 - cells[k][j]]) cnt++;
          else if (!x[8 - cells[k][j]] && !o[8 - cells[k][j]]) begin emp++; epos = cells[k][j]; end
        end
        if (cnt == 2 && emp == 1) begin
          mv[8 - epos] = 1'b1;
          lat = 2 + ph * 8 + k;
          return;
        end
      end
    end
    lat = 18;
    if (!x[4] && !o[4]) begin mv[4] = 1'b1; return; end
    for (int p = 0; p < 9; p += 2) begin
      if (p == 4) continue;
      if (!x[8 - p] && !o[8 - p]) begin mv[8 - p] = 1'b1; return; end
    end
    for (int p = 0; p < 9; p++) begin
      if (!x[8 - p] && !o[8 - p]) begin mv[8 - p] = 1'b1; return; end
    end
  endfunction

  task automatic run3(input logic [8:0] xv, input logic [8:0] ov, input logic aix,
                      input logic [8:0] emv, input logic eer, input int elat, input string name);
    int e;
    @(negedge clk);
    x_state = xv; o_state = ov; ai_is_x = aix; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " busy@0"}, busy, 1);
    check({name, " move cleared@0"}, {err, move}, 0);
    x_state = 9'($urandom); o_state = 9'($urandom); ai_is_x = 1'($urandom);
    e = 0;
    while (done !== 1'b1 && e < 100) begin
      @(posedge clk); #1;
      e++;
    end
    check({name, " done edge"}, e, elat);
    check({name, " move"}, move, emv);
    check({name, " err"}, err, eer);
    @(posedge clk); #1;
    check({name, " done/busy after"}, {done, busy}, 0);
    @(posedge clk); #1;
    check({name, " move held"}, {err, move}, {eer, emv});
  endtask

  initial begin
    logic [8:0] rx, ro, emv;
    logic       raix, eer;
    int         elat, e, pulses, done_e;
    logic [8:0] done_mv;

    tbl[0] = '{9'b000000000, 9'b000000000, 1'b1, 9'b000010000, 1'b0, 18};
    tbl[1] = '{9'b110000000, 9'b000011000, 1'b1, 9'b001000000, 1'b0, 2};
    tbl[2] = '{9'b100000000, 9'b000011000, 1'b1, 9'b000100000, 1'b0, 11};
    tbl[3] = '{9'b000010000, 9'b000010000, 1'b1, 9'b000000000, 1'b1, 2};
    tbl[4] = '{9'b101011010, 9'b010100101, 1'b1, 9'b000000000, 1'b0, 2};
    tbl[5] = '{9'b000011000, 9'b110000000, 1'b0, 9'b001000000, 1'b0, 2};
    tbl[6] = '{9'b000010000, 9'b000000000, 1'b0, 9'b100000000, 1'b0, 18};

    rst_n = 1'b0; start = 1'b0; ai_is_x = 1'b0; x_state = '0; o_state = '0;
    start4 = 1'b0; x4 = '0; o4 = '0;
    #12;
    check("reset outputs", {busy, done, err, move}, 0);
    check("reset outputs N4", {busy4, done4, err4, move4}, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run3(tbl[i].x, tbl[i].o, tbl[i].aix, tbl[i].mv, tbl[i].er, tbl[i].lat, $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      rx = '0; ro = '0;
      for (int p = 0; p < 9; p++) begin
        case ($urandom_range(0, 4))
          0: rx[p] = 1'b1;
          1: ro[p] = 1'b1;
          default: ;
        endcase
      end
      if ($urandom_range(0, 9) == 0) begin
        e = $urandom_range(0, 8);
        rx[e] = 1'b1; ro[e] = 1'b1;
      end
      raix = 1'($urandom);
      model(rx, ro, raix, emv, eer, elat);
      run3(rx, ro, raix, emv, eer, elat, $sformatf("rnd%0d", i));
    end

    // start re-pulsed while busy must be ignored
    @(negedge clk);
    x_state = '0; o_state = '0; ai_is_x = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; done_e = -1; done_mv = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k >= 3 && k <= 5);
      if (start) begin x_state = 9'h1FF; o_state = 9'h0F0; end
      @(posedge clk); #1;
      if (done === 1'b1) begin pulses++; done_e = k; done_mv = move; end
    end
    start = 1'b0;
    check("repulse pulses", pulses, 1);
    check("repulse edge", done_e, 18);
    check("repulse move", done_mv, 9'b000010000);

    // reset mid-operation
    run3(tbl[1].x, tbl[1].o, tbl[1].aix, tbl[1].mv, tbl[1].er, tbl[1].lat, "pre-reset");
    @(negedge clk);
    x_state = '0; o_state = '0; ai_is_x = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset outputs", {busy, done, err, move}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    check("midreset no done", pulses, 0);
    run3(tbl[2].x, tbl[2].o, tbl[2].aix, tbl[2].mv, tbl[2].er, tbl[2].lat, "post-reset");

    // N=4 empty board: even N skips centre, TL corner
    @(negedge clk);
    x4 = '0; o4 = '0; ai_is_x = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    e = 0;
    while (done4 !== 1'b1 && e < 100) begin
      @(posedge clk); #1;
      e++;
    end
    check("n4 done edge", e, 22);
    check("n4 move", move4, 16'h8000);
    check("n4 err", err4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
